bilinear_window_fetch_mc: RTL and testbench
===========================================

Name: bilinear_window_fetch_mc

Overview:
- Multi-channel, backpressure-aware successor to the bilinear line-buffer/stream controller.
- Buffers the incoming raster frame in a two-row circular line store.
- Walks destination coordinates (destx_o/desty_o) for the external coordinate generator and fetches the 2x2 source neighbourhood for every destination pixel, for all channels in parallel.
- Sits between the video input stream and the bilinear weight/MAC stage, which now drives m_tready_i.

Parameters:
- CHANNELS, 3, pixel components per beat; all channels share addressing.
- DATA_WIDTH, 8, bits per component.
- MAX_WIDTH, 2048, maximum src_width_i; sets line-store depth per row.
- INDEX_WIDTH, 16, width of coordinate ports.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset.
- s_tvalid_i  in  1  input beat valid.
- s_tdata_i  in  CHANNELS*DATA_WIDTH  input pixel; channel 0 is in the LSBs.
- s_tuser_i  in  1  start of frame; marks the first pixel of a frame.
- s_tready_o  out  1  input ready.
- src_width_i, src_height_i, dest_width_i, dest_height_i  in  16 each  frame geometry.
- srcx_int_i, srcy_int_i  in  INDEX_WIDTH each  integer source coordinate for the current destx_o/desty_o; combinational from the generator, valid in the same cycle.
- destx_o, desty_o  out  INDEX_WIDTH each  destination coordinate being issued.
- m_tvalid_o  out  1  output window valid.
- m_tready_i  in  1  downstream ready.
- m_tdata00_o, m_tdata01_o, m_tdata10_o, m_tdata11_o  out  CHANNELS*DATA_WIDTH each  taps (y,x), (y,x+1), (y+1,x), (y+1,x+1).
- m_tuser_o  out  1  first window of frame.
- m_tlast_o  out  1  last window of a destination row.
- frame_done_o  out  1  one-cycle pulse when the frame is fully consumed.
- err_sof_o  out  1  one-cycle pulse on an unexpected SOF.

Behaviour:
- Reset (rst_i=1 at a clock edge):
  - all counters, FSM and pipeline valids clear;
  - m_tvalid_o, m_tuser_o, m_tlast_o, frame_done_o, err_sof_o, s_tready_o = 0;
  - destx_o = desty_o = 0; tap data outputs = 0.
  - Reset mid-frame discards all buffered data; the next frame must begin with s_tuser_i.
- Geometry latch:
  - Geometry inputs are latched on the accepted SOF beat and held constant for the whole frame.
  - Non-SOF beats in IDLE are accepted (s_tready_o=1 in IDLE) and dropped.
- Write side:
  - An input beat is accepted on s_tvalid_i & s_tready_o.
  - Source row r is written to line slot r[0] at column wx. wx wraps at src_width-1, and rows_written then increments.
  - Outside IDLE, s_tready_o = (rows_written < row_y+2) & (rows_written < src_height). row_y is the srcy latched at the start of the current destination row.
  - An accepted s_tuser_i outside IDLE pulses err_sof_o; that beat is stored as ordinary data.
- Read pipeline:
  - Issue happens when the FSM is in ISSUE and the pipeline skid has space.
  - Issue cycle: srcx/srcy are sampled. Registered addresses are formed with x1 = min(x+1, W-1) and y1 = min(y+1, H-1), so at the right and bottom edges the taps duplicate.
  - +1: RAM read.
  - +2: output register.
  - Minimum latency from issue to m_tvalid_o is 3 cycles.
  - Two-entry skid: with m_tready_i low the outputs hold stable, no window is lost or duplicated, and issue stalls.
  - Full throughput is 1 window per clock.
- FSM:
  - IDLE: wait for the SOF beat; go to WAIT_ROWS.
  - WAIT_ROWS: latch row_y = srcy_int_i. Go to ISSUE when rows_written >= row_y+2, or when row_y+1 >= src_height and rows_written == src_height.
  - ISSUE: destx increments per issue. On the issue with destx = dest_width-1, destx wraps and the FSM goes to DRAIN.
  - DRAIN: wait until the pipeline and skid are empty.
    - If desty = dest_height-1: desty <- 0 and go to FLUSH.
    - Otherwise: desty increments and go to WAIT_ROWS.
  - FLUSH: s_tready_o=1; accept and discard beats until rows_written == src_height, then go to DONE.
  - DONE: pulse frame_done_o for one cycle; go to IDLE.
- Sideband timing:
  - m_tuser_o accompanies window (0,0).
  - m_tlast_o accompanies windows with destx = dest_width-1.
- Arithmetic: counters are 16 bits. The bench guarantees src_width <= MAX_WIDTH and src_width, src_height >= 2; behaviour otherwise is undefined.

Test Plan:
- 4x4 src with pixel = 16*y+x per channel, 4x4 dest, identity generator, m_tready_i=1 -> 16 windows; window (1,2) taps = 18,19,34,35; m_tlast_o on destx=3; m_tuser_o only on the first window; frame_done_o pulses once.
- Same frame with m_tready_i toggling 1-0-0-1 pseudo-randomly -> the window sequence is identical to the unstalled run, with no drops or duplicates; outputs stay stable while stalled.
- Edge clamp: 4x4 src, srcx=3, srcy=3 -> all four taps = 51 on every channel.
- Scale-down: 8x8 src -> 4x4 dest, srcy = 2*desty -> after window (3,3), FLUSH accepts the remaining rows; frame_done_o fires only after all 64 input beats are accepted.
- CHANNELS=3 with distinct per-channel values (c*64 + pixel index) -> each channel field is independent and correctly ordered.
- Reset asserted during ISSUE of row 2, then a new frame is sent -> all outputs are 0 in the cycle after reset; the second frame's output is bit-exact with a fresh run.
- A spurious s_tuser_i on pixel 5 -> err_sof_o pulses one cycle; the window stream is unchanged.

Source files
------------

// File: rtl/bilinear_window_fetch_mc_if.sv
// rtl/bilinear_window_fetch_mc_if.sv - stream, geometry and window bundle for bilinear_window_fetch_mc
interface bilinear_window_fetch_mc_if #(
  parameter int CHANNELS    = 3,
  parameter int DATA_WIDTH  = 8,
  parameter int INDEX_WIDTH = 16
);
  localparam int PW = CHANNELS * DATA_WIDTH;

  logic                   s_tvalid_i;
  logic [PW-1:0]          s_tdata_i;
  logic                   s_tuser_i;
  logic                   s_tready_o;
  logic [15:0]            src_width_i;
  logic [15:0]            src_height_i;
  logic [15:0]            dest_width_i;
  logic [15:0]            dest_height_i;
  logic [INDEX_WIDTH-1:0] srcx_int_i;
  logic [INDEX_WIDTH-1:0] srcy_int_i;
  logic [INDEX_WIDTH-1:0] destx_o;
  logic [INDEX_WIDTH-1:0] desty_o;
  logic                   m_tvalid_o;
  logic                   m_tready_i;
  logic [PW-1:0]          m_tdata00_o;
  logic [PW-1:0]          m_tdata01_o;
  logic [PW-1:0]          m_tdata10_o;
  logic [PW-1:0]          m_tdata11_o;
  logic                   m_tuser_o;
  logic                   m_tlast_o;
  logic                   frame_done_o;
  logic                   err_sof_o;

  modport slave (
    input  s_tvalid_i, s_tdata_i, s_tuser_i, src_width_i, src_height_i, dest_width_i,
           dest_height_i, srcx_int_i, srcy_int_i, m_tready_i,
    output s_tready_o, destx_o, desty_o, m_tvalid_o, m_tdata00_o, m_tdata01_o,
           m_tdata10_o, m_tdata11_o, m_tuser_o, m_tlast_o, frame_done_o, err_sof_o
  );

  modport master (
    output s_tvalid_i, s_tdata_i, s_tuser_i, src_width_i, src_height_i, dest_width_i,
           dest_height_i, srcx_int_i, srcy_int_i, m_tready_i,
    input  s_tready_o, destx_o, desty_o, m_tvalid_o, m_tdata00_o, m_tdata01_o,
           m_tdata10_o, m_tdata11_o, m_tuser_o, m_tlast_o, frame_done_o, err_sof_o
  );
endinterface

// File: rtl/bilinear_window_fetch_mc.sv
// rtl/bilinear_window_fetch_mc.sv - two-row line store and 2x2 multi-channel window fetch with skid buffer
module bilinear_window_fetch_mc #(
  parameter int CHANNELS    = 3,
  parameter int DATA_WIDTH  = 8,
  parameter int MAX_WIDTH   = 2048,
  parameter int INDEX_WIDTH = 16
) (
  input logic clk_i,
  input logic rst_i,
  bilinear_window_fetch_mc_if.slave bus
);
  localparam int PW = CHANNELS * DATA_WIDTH;
  localparam int AW = $clog2(MAX_WIDTH);
  localparam int WW = 4 * PW + 2;

  typedef enum logic [2:0] {IDLE, WAIT_ROWS, ISSUE, DRAIN, FLUSH, DONE} state_t;
  state_t state, state_nx;

  logic                   armed, err_sof;
  logic [15:0]            src_w, src_h, dst_w, dst_h, wx, rows_written, row_y;
  logic [INDEX_WIDTH-1:0] destx, desty;
  logic [PW-1:0]          line0 [MAX_WIDTH];
  logic [PW-1:0]          line1 [MAX_WIDTH];

  logic        s_ready, accept, sof_in, wr_en, issue, pop, pipe_empty, rows_ready, last_x, last_y;
  logic [31:0] sx, sy, rw, h;
  logic [AW-1:0] sx1;
  logic        sy1_slot;
  logic [2:0]  occ;

  logic          va, ay0, ay1, a_user, a_last;
  logic [AW-1:0] ax0, ax1;
  logic          vb, b_user, b_last;
  logic [PW-1:0] b00, b01, b10, b11;
  logic [WW-1:0] fifo [3];
  logic [WW-1:0] head;
  logic [1:0]    rd_ptr, wr_ptr, cnt;

  // Edge clamping duplicates the last column/row rather than reading past the frame.
  always_comb begin
    sx         = 32'(bus.srcx_int_i);
    sy         = 32'(bus.srcy_int_i);
    rw         = 32'(rows_written);
    h          = 32'(src_h);
    sx1        = AW'((sx + 32'd1 >= 32'(src_w)) ? 32'(src_w) - 32'd1 : sx + 32'd1);
    sy1_slot   = 1'((sy + 32'd1 >= h) ? h - 32'd1 : sy + 32'd1);
    rows_ready = (rw >= sy + 32'd2) || ((sy + 32'd1 >= h) && (rw == h));
    last_x     = (32'(destx) == 32'(dst_w) - 32'd1);
    last_y     = (32'(desty) == 32'(dst_h) - 32'd1);
    occ        = 3'(va) + 3'(vb) + 3'(cnt);
    pop        = (cnt != 2'd0) && bus.m_tready_i;
    pipe_empty = !va && !vb && (cnt == 2'd0);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      if (sof_in) state_nx = WAIT_ROWS;
      WAIT_ROWS: if (rows_ready) state_nx = ISSUE;
      ISSUE:     if (issue && last_x) state_nx = DRAIN;
      DRAIN:     if (pipe_empty) state_nx = last_y ? FLUSH : WAIT_ROWS;
      FLUSH:     if (rows_written == src_h) state_nx = DONE;
      DONE:      state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  // Writes stop once the two rows of the current destination row are resident.
  always_comb begin
    s_ready = 1'b0;
    case (state)
      IDLE, FLUSH: s_ready = armed;
      default:     s_ready = (rw < 32'(row_y) + 32'd2) && (rw < h);
    endcase
    accept = bus.s_tvalid_i && s_ready;
    sof_in = accept && bus.s_tuser_i && (state == IDLE);
    wr_en  = sof_in || (accept && (state != IDLE));
    issue  = (state == ISSUE) && ((occ - 3'(pop)) < 3'd3);
    head   = fifo[rd_ptr];
    bus.s_tready_o    = s_ready;
    bus.m_tvalid_o    = (cnt != 2'd0);
    bus.m_tuser_o     = (cnt != 2'd0) && head[WW-1];
    bus.m_tlast_o     = (cnt != 2'd0) && head[WW-2];
    bus.m_tdata00_o   = head[4*PW-1:3*PW];
    bus.m_tdata01_o   = head[3*PW-1:2*PW];
    bus.m_tdata10_o   = head[2*PW-1:PW];
    bus.m_tdata11_o   = head[PW-1:0];
    bus.frame_done_o  = (state == DONE);
    bus.err_sof_o     = err_sof;
    bus.destx_o       = destx;
    bus.desty_o       = desty;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      armed        <= 1'b0;
      err_sof      <= 1'b0;
      src_w        <= '0;
      src_h        <= '0;
      dst_w        <= '0;
      dst_h        <= '0;
      wx           <= '0;
      rows_written <= '0;
      row_y        <= '0;
      destx        <= '0;
      desty        <= '0;
    end else begin
      armed   <= 1'b1;
      err_sof <= accept && bus.s_tuser_i && (state != IDLE);
      if (sof_in) begin
        src_w        <= bus.src_width_i;
        src_h        <= bus.src_height_i;
        dst_w        <= bus.dest_width_i;
        dst_h        <= bus.dest_height_i;
        wx           <= 16'd1;
        rows_written <= '0;
        row_y        <= '0;
      end else if (accept && (state != IDLE)) begin
        if (wx == src_w - 16'd1) begin
          wx           <= '0;
          rows_written <= rows_written + 16'd1;
        end else begin
          wx <= wx + 16'd1;
        end
      end
      if (state == WAIT_ROWS) row_y <= 16'(bus.srcy_int_i);
      if (issue) destx <= last_x ? '0 : destx + INDEX_WIDTH'(1);
      if ((state == DRAIN) && pipe_empty) desty <= last_y ? '0 : desty + INDEX_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      if (!sof_in && rows_written[0]) line1[wx[AW-1:0]] <= bus.s_tdata_i;
      else                            line0[sof_in ? '0 : wx[AW-1:0]] <= bus.s_tdata_i;
    end
    if (va) begin
      b00    <= ay0 ? line1[ax0] : line0[ax0];
      b01    <= ay0 ? line1[ax1] : line0[ax1];
      b10    <= ay1 ? line1[ax0] : line0[ax0];
      b11    <= ay1 ? line1[ax1] : line0[ax1];
      b_user <= a_user;
      b_last <= a_last;
    end
  end

  // Three result slots (output head plus two skid entries) cover the whole issue-to-output pipe.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      va     <= 1'b0;
      vb     <= 1'b0;
      ax0    <= '0;
      ax1    <= '0;
      ay0    <= 1'b0;
      ay1    <= 1'b0;
      a_user <= 1'b0;
      a_last <= 1'b0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < 3; i++) fifo[i] <= '0;
    end else begin
      va <= issue;
      if (issue) begin
        ax0    <= sx[AW-1:0];
        ax1    <= sx1;
        ay0    <= sy[0];
        ay1    <= sy1_slot;
        a_user <= (destx == '0) && (desty == '0);
        a_last <= last_x;
      end
      vb <= va;
      if (vb) begin
        fifo[wr_ptr] <= {b_user, b_last, b00, b01, b10, b11};
        wr_ptr       <= (wr_ptr == 2'd2) ? 2'd0 : wr_ptr + 2'd1;
      end
      if (pop) rd_ptr <= (rd_ptr == 2'd2) ? 2'd0 : rd_ptr + 2'd1;
      cnt <= cnt + 2'(vb) - 2'(pop);
    end
  end
endmodule

// File: tb/tb_bilinear_window_fetch_mc.sv
// tb/tb_bilinear_window_fetch_mc.sv - directed self-checking bench for bilinear_window_fetch_mc
module tb_bilinear_window_fetch_mc;
  localparam int PW = 24;

  typedef struct packed {
    logic          user;
    logic          last;
    logic [PW-1:0] t00;
    logic [PW-1:0] t01;
    logic [PW-1:0] t10;
    logic [PW-1:0] t11;
  } win_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bilinear_window_fetch_mc_if bus ();
  bilinear_window_fetch_mc dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  int   n_vec = 0;
  int   n_bad = 0;
  int   gmode = 0;
  win_t got[$];
  int   done_cnt, err_cnt, beats_acc, beats_at_done;
  bit   stall_mode = 1'b0;
  bit   abort = 1'b0;
  bit   was_stalled = 1'b0;
  win_t held, cur;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // 0: identity, 1: pinned to (3,3), 2: 2x decimation
  function automatic int gen(input int mode, input int d);
    case (mode)
      0:       return d;
      1:       return 3;
      default: return 2 * d;
    endcase
  endfunction

  always_comb begin
    bus.srcx_int_i = 16'(gen(gmode, int'(bus.destx_o)));
    bus.srcy_int_i = 16'(gen(gmode, int'(bus.desty_o)));
  end

  function automatic logic [PW-1:0] pix(input int y, input int x);
    int p = 16 * y + x;
    return {8'(128 + p), 8'(64 + p), 8'(p)};
  endfunction

  function automatic win_t model(input int w, input int h, input int dw, input int dx, input int dy);
    win_t r;
    int sx = gen(gmode, dx);
    int sy = gen(gmode, dy);
    int x1 = (sx + 1 >= w) ? w - 1 : sx + 1;
    int y1 = (sy + 1 >= h) ? h - 1 : sy + 1;
    r.user = (dx == 0) && (dy == 0);
    r.last = (dx == dw - 1);
    r.t00  = pix(sy, sx);
    r.t01  = pix(sy, x1);
    r.t10  = pix(y1, sx);
    r.t11  = pix(y1, x1);
    return r;
  endfunction

  initial forever begin
    @(negedge clk);
    bus.m_tready_i = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    #1;
    cur = {bus.m_tuser_o, bus.m_tlast_o, bus.m_tdata00_o, bus.m_tdata01_o, bus.m_tdata10_o, bus.m_tdata11_o};
    if (rst) begin
      was_stalled = 1'b0;
    end else begin
      if (bus.frame_done_o) begin
        done_cnt++;
        beats_at_done = beats_acc;
      end
      if (bus.err_sof_o) err_cnt++;
      if (was_stalled) begin
        check("stall_valid_held", bus.m_tvalid_o, 1'b1);
        check("stall_data_held", cur, held);
      end
      if (bus.m_tvalid_o && bus.m_tready_i) got.push_back(cur);
      was_stalled = bus.m_tvalid_o && !bus.m_tready_i;
      held = cur;
    end
  end

  task automatic send_frame(input int w, input int h, input int spur);
    int i = 0;
    int guard = 0;
    while (i < w * h && !abort && guard < 20000) begin
      @(negedge clk);
      bus.s_tvalid_i = 1'b1;
      bus.s_tdata_i  = pix(i / w, i % w);
      bus.s_tuser_i  = (i == 0) || (i == spur);
      #1;
      if (bus.s_tready_o) begin
        i++;
        beats_acc++;
      end
      guard++;
    end
    @(negedge clk);
    bus.s_tvalid_i = 1'b0;
    bus.s_tuser_i  = 1'b0;
    if (!abort) check("beats_sent", i, w * h);
  endtask

  task automatic set_geometry(input int w, input int h, input int dw, input int dh, input int mode);
    gmode              = mode;
    bus.src_width_i    = 16'(w);
    bus.src_height_i   = 16'(h);
    bus.dest_width_i   = 16'(dw);
    bus.dest_height_i  = 16'(dh);
    got.delete();
    done_cnt      = 0;
    err_cnt       = 0;
    beats_acc     = 0;
    beats_at_done = -1;
  endtask

  task automatic run_frame(input int w, input int h, input int dw, input int dh,
                           input int mode, input int spur, input bit stall);
    set_geometry(w, h, dw, dh, mode);
    stall_mode = stall;
    fork
      send_frame(w, h, spur);
      begin
        for (int c = 0; c < 3000 && done_cnt == 0; c++) @(negedge clk);
        repeat (4) @(negedge clk);
      end
    join
    stall_mode = 1'b0;
    check("frame_done_pulses", done_cnt, 1);
  endtask

  task automatic check_stream(input int w, input int h, input int dw, input int dh);
    check("window_count", got.size(), dw * dh);
    for (int i = 0; i < got.size() && i < dw * dh; i++)
      check($sformatf("window_%0d", i), got[i], model(w, h, dw, i % dw, i / dw));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_m_tvalid"}, bus.m_tvalid_o, 1'b0);
    check({tag, "_m_tuser"}, bus.m_tuser_o, 1'b0);
    check({tag, "_m_tlast"}, bus.m_tlast_o, 1'b0);
    check({tag, "_frame_done"}, bus.frame_done_o, 1'b0);
    check({tag, "_err_sof"}, bus.err_sof_o, 1'b0);
    check({tag, "_s_tready"}, bus.s_tready_o, 1'b0);
    check({tag, "_destx"}, bus.destx_o, 16'd0);
    check({tag, "_desty"}, bus.desty_o, 16'd0);
    check({tag, "_tap00"}, bus.m_tdata00_o, 24'd0);
    check({tag, "_tap01"}, bus.m_tdata01_o, 24'd0);
    check({tag, "_tap10"}, bus.m_tdata10_o, 24'd0);
    check({tag, "_tap11"}, bus.m_tdata11_o, 24'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    win_t w6;
    int   c;
    bus.s_tvalid_i = 1'b0;
    bus.s_tuser_i  = 1'b0;
    bus.s_tdata_i  = '0;
    bus.m_tready_i = 1'b1;
    set_geometry(4, 4, 4, 4, 0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check_reset_outputs("rst_init");
    rst = 1'b0;

    run_frame(4, 4, 4, 4, 0, -1, 1'b0);
    check_stream(4, 4, 4, 4);
    w6 = (got.size() > 6) ? got[6] : '0;
    check("w_y1x2_t00_c0", w6.t00[7:0], 8'd18);
    check("w_y1x2_t01_c0", w6.t01[7:0], 8'd19);
    check("w_y1x2_t10_c0", w6.t10[7:0], 8'd34);
    check("w_y1x2_t11_c0", w6.t11[7:0], 8'd35);
    check("w_y1x2_t00_c1", w6.t00[15:8], 8'd82);
    check("w_y1x2_t11_c2", w6.t11[23:16], 8'd163);

    run_frame(4, 4, 4, 4, 0, -1, 1'b1);
    check_stream(4, 4, 4, 4);

    run_frame(4, 4, 2, 2, 1, -1, 1'b0);
    check_stream(4, 4, 2, 2);
    for (int i = 0; i < got.size(); i++)
      check($sformatf("clamp_taps_%0d", i), {got[i].t00, got[i].t01, got[i].t10, got[i].t11},
            {4{24'hB37333}});

    run_frame(8, 8, 4, 4, 2, -1, 1'b0);
    check_stream(8, 8, 4, 4);
    check("beats_at_frame_done", beats_at_done, 64);

    run_frame(4, 4, 4, 4, 0, 5, 1'b0);
    check("err_sof_pulses", err_cnt, 1);
    check_stream(4, 4, 4, 4);

    set_geometry(4, 4, 4, 4, 0);
    fork
      send_frame(4, 4, -1);
      begin
        c = 0;
        do begin
          @(negedge clk);
          #2;
          c++;
        end while (!(bus.desty_o == 16'd2 && bus.destx_o == 16'd1) && c < 2000);
        check("reached_row2_issue", c < 2000, 1'b1);
        rst   = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        @(negedge clk);
        #1;
        check_reset_outputs("rst_mid");
        rst = 1'b0;
      end
    join
    abort = 1'b0;
    run_frame(4, 4, 4, 4, 0, -1, 1'b0);
    check_stream(4, 4, 4, 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
